// File: rtl/dff_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dff_arb_pkg
// Shared definitions for the dff_bank_arbiter slice: FSM state encoding and
// default sizing constants used by the interface, the picker and the top.
// No ports (package).
// -----------------------------------------------------------------------------
package dff_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_WIDTH       = 4;
  localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter_if
// Bundles the requester-side bus of the shared-register arbiter.
//   req     : per-requester request level           (master -> slave)
//   wdata   : packed write data, lane i = [i*WIDTH +: WIDTH]
//   clr     : synchronous clear of the shared register
//   grant   : one-hot registered grant               (slave -> master)
//   ack     : one-cycle load-done pulse to the owner
//   owner   : index of the current or last owner
//   q       : shared register contents
//   q_valid : q holds loaded, non-cleared data
//   busy    : arbiter FSM is not idle
// -----------------------------------------------------------------------------
interface dff_bank_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  localparam int IDXW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic                     clr;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic [IDXW-1:0]          owner;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic                     busy;

  modport master (
    output req, wdata, clr,
    input  grant, ack, owner, q, q_valid, busy
  );

  modport slave (
    input  req, wdata, clr,
    output grant, ack, owner, q, q_valid, busy
  );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set req bit found by
// scanning upward from rr_ptr and wrapping from NUM_REQ-1 back to 0.
//   req    : request vector
//   rr_ptr : index where the search starts (highest priority)
//   winner : index of the selected requester (0 when none)
//   found  : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDXW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [IDXW-1:0]    winner,
  output logic               found
);

  // Walk offsets 0..NUM_REQ-1 from rr_ptr; the first hit wins and later
  // hits are masked by found.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[IDXW-1:0]]) begin
        winner = idx[IDXW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
// Round-robin sequencer that is the single write path into a shared WIDTH-bit
// register. One requester is granted, its data is loaded one cycle later with
// an ack pulse, and the grant is kept for a bounded hold window.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (0 = in reset)
//   bus   : slave side of dff_bank_arbiter_if (req/wdata/clr in,
//           grant/ack/owner/q/q_valid/busy out)
// -----------------------------------------------------------------------------
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input logic               clk,
  input logic               reset,
  dff_bank_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  // hold_cnt only ever holds HOLD_CYCLES-1 down to 0.
  localparam int HCW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t             state;
  state_t             next_state;
  logic [IDXW-1:0]    rr_ptr;
  logic [IDXW-1:0]    owner_r;
  logic [IDXW-1:0]    winner;
  logic               found;
  logic [HCW-1:0]     hold_cnt;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] ack_r;
  logic [WIDTH-1:0]   q_r;
  logic               q_valid_r;
  logic               release_now;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  // Dropping the request ends the hold early; otherwise it ends when the
  // counter has run out.
  assign release_now = (state == ST_HOLD) &&
                       (!bus.req[owner_r] || (hold_cnt == '0));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (found) next_state = ST_LOAD;
      ST_LOAD: next_state = ST_HOLD;
      ST_HOLD: if (release_now) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath. clr is applied last so it overrides the
  // LOAD write at the same edge while ack still pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_r   <= '0;
      ack_r     <= '0;
      owner_r   <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      ack_r <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner_r <= winner;
            grant_r <= ONE << winner;
          end else begin
            grant_r <= '0;
          end
        end
        ST_LOAD: begin
          q_r       <= bus.wdata[int'(owner_r)*WIDTH +: WIDTH];
          q_valid_r <= 1'b1;
          ack_r     <= ONE << owner_r;
          hold_cnt  <= HCW'(HOLD_CYCLES - 1);
        end
        ST_HOLD: begin
          if (release_now) begin
            grant_r <= '0;
            rr_ptr  <= (owner_r == IDXW'(NUM_REQ - 1)) ? '0 : owner_r + IDXW'(1);
          end else begin
            hold_cnt <= hold_cnt - HCW'(1);
          end
        end
        default: grant_r <= '0;
      endcase
      if (bus.clr) begin
        q_r       <= '0;
        q_valid_r <= 1'b0;
      end
    end
  end

  // Output drive; busy is decoded straight from the state register.
  always_comb begin
    bus.grant   = grant_r;
    bus.ack     = ack_r;
    bus.owner   = owner_r;
    bus.q       = q_r;
    bus.q_valid = q_valid_r;
    bus.busy    = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
// Directed bench for dff_bank_arbiter. u_dut0 uses HOLD_CYCLES=2 and u_dut1
// uses HOLD_CYCLES=1; both share clock and reset.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  dff_bank_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus0 ();
  dff_bank_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus1 ();

  dff_bank_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD_CYCLES(2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dff_bank_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset both instances and leave all inputs idle.
  task automatic do_reset;
    reset      = 1'b0;
    bus0.req   = '0;
    bus0.wdata = '0;
    bus0.clr   = 1'b0;
    bus1.req   = '0;
    bus1.wdata = '0;
    bus1.clr   = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    bus0.req   = '0;
    bus0.wdata = '0;
    bus0.clr   = 1'b0;
    bus1.req   = '0;
    bus1.wdata = '0;
    bus1.clr   = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus0.grant !== 4'b0) begin failed++; $display("[TB] FAIL rst_grant: got %b expected %b", bus0.grant, 4'b0); end else passed++;
    checks++; if (bus0.ack !== 4'b0) begin failed++; $display("[TB] FAIL rst_ack: got %b expected %b", bus0.ack, 4'b0); end else passed++;
    checks++; if ({bus0.q, bus0.q_valid, bus0.owner, bus0.busy} !== 8'h00) begin failed++; $display("[TB] FAIL rst_q_owner_busy: got %h expected %h", {bus0.q, bus0.q_valid, bus0.owner, bus0.busy}, 8'h00); end else passed++;
    tick;
    reset = 1'b1;
    tick;
    checks++; if (bus0.busy !== 1'b0) begin failed++; $display("[TB] FAIL rst_idle_busy: got %b expected %b", bus0.busy, 1'b0); end else passed++;
  endtask

  task automatic test_basic_load;
    do_reset;
    bus0.wdata = 16'h1A23;
    bus0.req   = 4'b0100;
    tick;
    checks++; if (bus0.grant !== 4'b0100) begin failed++; $display("[TB] FAIL basic_grant_e1: got %b expected %b", bus0.grant, 4'b0100); end else passed++;
    checks++; if (bus0.busy !== 1'b1) begin failed++; $display("[TB] FAIL basic_busy_e1: got %b expected %b", bus0.busy, 1'b1); end else passed++;
    checks++; if (bus0.ack !== 4'b0000) begin failed++; $display("[TB] FAIL basic_ack_e1: got %b expected %b", bus0.ack, 4'b0000); end else passed++;
    tick;
    checks++; if (bus0.q !== 4'hA) begin failed++; $display("[TB] FAIL basic_q_e2: got %h expected %h", bus0.q, 4'hA); end else passed++;
    checks++; if (bus0.q_valid !== 1'b1) begin failed++; $display("[TB] FAIL basic_qvalid_e2: got %b expected %b", bus0.q_valid, 1'b1); end else passed++;
    checks++; if (bus0.ack !== 4'b0100) begin failed++; $display("[TB] FAIL basic_ack_e2: got %b expected %b", bus0.ack, 4'b0100); end else passed++;
    tick;
    checks++; if (bus0.ack !== 4'b0000) begin failed++; $display("[TB] FAIL basic_ack_e3: got %b expected %b", bus0.ack, 4'b0000); end else passed++;
    checks++; if ({bus0.grant, bus0.busy} !== 5'b0100_1) begin failed++; $display("[TB] FAIL basic_grant_busy_e3: got %b expected %b", {bus0.grant, bus0.busy}, 5'b0100_1); end else passed++;
    tick;
    checks++; if ({bus0.grant, bus0.busy} !== 5'b0000_0) begin failed++; $display("[TB] FAIL basic_release_e4: got %b expected %b", {bus0.grant, bus0.busy}, 5'b0000_0); end else passed++;
    bus0.req = 4'b0000;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_idx;
    logic [3:0] exp_oh;
    logic [3:0] exp_q;
    do_reset;
    bus0.wdata = 16'h4321;
    bus0.req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_idx = 2'(k);
      exp_oh  = 4'b0001 << exp_idx;
      exp_q   = 4'(exp_idx) + 4'd1;
      tick;
      checks++; if (bus0.grant !== exp_oh) begin failed++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, bus0.grant, exp_oh); end else passed++;
      checks++; if (bus0.owner !== exp_idx) begin failed++; $display("[TB] FAIL rr_owner_%0d: got %0d expected %0d", k, bus0.owner, exp_idx); end else passed++;
      tick;
      checks++; if ({bus0.ack, bus0.q} !== {exp_oh, exp_q}) begin failed++; $display("[TB] FAIL rr_ack_q_%0d: got %h expected %h", k, {bus0.ack, bus0.q}, {exp_oh, exp_q}); end else passed++;
      tick;
      tick;
      checks++; if ({bus0.grant, bus0.busy} !== 5'b0000_0) begin failed++; $display("[TB] FAIL rr_idle_gap_%0d: got %b expected %b", k, {bus0.grant, bus0.busy}, 5'b0000_0); end else passed++;
    end
    bus0.req = 4'b0000;
  endtask

  task automatic test_early_release;
    do_reset;
    bus0.wdata = 16'h4321;
    bus0.req   = 4'b1010;
    tick;
    checks++; if ({bus0.grant, bus0.owner} !== 6'b0010_01) begin failed++; $display("[TB] FAIL early_grant1: got %b expected %b", {bus0.grant, bus0.owner}, 6'b0010_01); end else passed++;
    tick;
    checks++; if ({bus0.ack, bus0.q} !== 8'b0010_0010) begin failed++; $display("[TB] FAIL early_load1: got %b expected %b", {bus0.ack, bus0.q}, 8'b0010_0010); end else passed++;
    bus0.req = 4'b1001;
    tick;
    checks++; if ({bus0.grant, bus0.busy} !== 5'b0000_0) begin failed++; $display("[TB] FAIL early_release: got %b expected %b", {bus0.grant, bus0.busy}, 5'b0000_0); end else passed++;
    tick;
    checks++; if ({bus0.grant, bus0.owner} !== 6'b1000_11) begin failed++; $display("[TB] FAIL early_next_grant: got %b expected %b", {bus0.grant, bus0.owner}, 6'b1000_11); end else passed++;
    bus0.req = 4'b0000;
    tick;
    checks++; if ({bus0.ack, bus0.q} !== 8'b1000_0100) begin failed++; $display("[TB] FAIL early_load_after_drop: got %b expected %b", {bus0.ack, bus0.q}, 8'b1000_0100); end else passed++;
    tick;
    checks++; if (bus0.grant !== 4'b0000) begin failed++; $display("[TB] FAIL early_release2: got %b expected %b", bus0.grant, 4'b0000); end else passed++;
  endtask

  task automatic test_clear;
    do_reset;
    bus0.wdata = 16'h000F;
    bus0.req   = 4'b0001;
    tick;
    checks++; if (bus0.grant !== 4'b0001) begin failed++; $display("[TB] FAIL clr_grant: got %b expected %b", bus0.grant, 4'b0001); end else passed++;
    bus0.clr = 1'b1;
    tick;
    checks++; if ({bus0.q, bus0.q_valid} !== 5'b0000_0) begin failed++; $display("[TB] FAIL clr_over_load: got %b expected %b", {bus0.q, bus0.q_valid}, 5'b0000_0); end else passed++;
    checks++; if (bus0.ack !== 4'b0001) begin failed++; $display("[TB] FAIL clr_ack: got %b expected %b", bus0.ack, 4'b0001); end else passed++;
    bus0.clr = 1'b0;
    tick;
    tick;
    checks++; if (bus0.grant !== 4'b0000) begin failed++; $display("[TB] FAIL clr_release: got %b expected %b", bus0.grant, 4'b0000); end else passed++;
    tick;
    tick;
    checks++; if ({bus0.q, bus0.q_valid} !== 5'b1111_1) begin failed++; $display("[TB] FAIL clr_reload: got %b expected %b", {bus0.q, bus0.q_valid}, 5'b1111_1); end else passed++;
    bus0.req = 4'b0000;
    bus0.clr = 1'b1;
    tick;
    checks++; if ({bus0.q, bus0.q_valid, bus0.grant} !== 9'b0000_0_0000) begin failed++; $display("[TB] FAIL clr_in_hold: got %b expected %b", {bus0.q, bus0.q_valid, bus0.grant}, 9'b0000_0_0000); end else passed++;
    bus0.clr = 1'b0;
  endtask

  task automatic test_reset_mid_hold;
    do_reset;
    bus0.wdata = 16'h0050;
    bus0.req   = 4'b0010;
    tick;
    tick;
    checks++; if ({bus0.q, bus0.grant, bus0.ack} !== 12'h522) begin failed++; $display("[TB] FAIL midrst_pre: got %h expected %h", {bus0.q, bus0.grant, bus0.ack}, 12'h522); end else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if ({bus0.grant, bus0.ack} !== 8'h00) begin failed++; $display("[TB] FAIL midrst_grant_ack: got %h expected %h", {bus0.grant, bus0.ack}, 8'h00); end else passed++;
    checks++; if ({bus0.q, bus0.q_valid, bus0.busy, bus0.owner} !== 8'h00) begin failed++; $display("[TB] FAIL midrst_q_busy: got %h expected %h", {bus0.q, bus0.q_valid, bus0.busy, bus0.owner}, 8'h00); end else passed++;
    #1 reset = 1'b1;
    tick;
    checks++; if ({bus0.grant, bus0.ack, bus0.q_valid} !== 9'b0010_0000_0) begin failed++; $display("[TB] FAIL midrst_restart: got %b expected %b", {bus0.grant, bus0.ack, bus0.q_valid}, 9'b0010_0000_0); end else passed++;
    bus0.req = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_short_hold;
    do_reset;
    bus1.wdata = 16'h0007;
    bus1.req   = 4'b0001;
    tick;
    checks++; if ({bus1.grant, bus1.ack} !== 8'b0001_0000) begin failed++; $display("[TB] FAIL short_e1: got %b expected %b", {bus1.grant, bus1.ack}, 8'b0001_0000); end else passed++;
    tick;
    checks++; if ({bus1.grant, bus1.ack, bus1.q} !== 12'b0001_0001_0111) begin failed++; $display("[TB] FAIL short_e2: got %b expected %b", {bus1.grant, bus1.ack, bus1.q}, 12'b0001_0001_0111); end else passed++;
    tick;
    checks++; if ({bus1.grant, bus1.ack, bus1.busy} !== 9'b0000_0000_0) begin failed++; $display("[TB] FAIL short_e3: got %b expected %b", {bus1.grant, bus1.ack, bus1.busy}, 9'b0000_0000_0); end else passed++;
    bus1.req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_basic_load;
    test_round_robin;
    test_early_release;
    test_clear;
    test_reset_mid_hold;
    test_short_hold;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one WIDTH-bit storage register among NUM_REQ requesters.
- Each requester raises req with its write data. The block grants one requester at a time, loads the data into the shared register and pulses ack.
- The owner keeps the grant for a bounded hold window, then arbitration restarts.
- Sits in front of the shared register bank as its only write path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, shared register width in bits
HOLD_CYCLES, 2, cycles the owner keeps grant after the load (>=1)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  per-requester request level
wdata  input  NUM_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
clr  input  1  synchronous clear of the shared register
grant  output  NUM_REQ  one-hot grant, registered
ack  output  NUM_REQ  one-cycle load-done pulse to the owner, registered
owner  output  $clog2(NUM_REQ)  index of the current or last owner
q  output  WIDTH  shared register contents
q_valid  output  1  q holds loaded (non-cleared) data
busy  output  1  high when state != IDLE (decoded from the state register)

Behaviour:
- Reset low, asynchronous, no clock needed:
  - state=IDLE, grant=0, ack=0, q=0, q_valid=0, owner=0, rr_ptr=0.
  - Any operation in progress is aborted; no ack is produced.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If |req, pick the winner w: first set req bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - Next edge: owner<=w, grant<=onehot(w), state<=LOAD.
  - No req: stay in IDLE, grant=0.
- LOAD (exactly one cycle):
  - q<=wdata[owner], q_valid<=1, ack[owner]<=1, hold_cnt<=HOLD_CYCLES-1, state<=HOLD.
  - A req drop during LOAD does not cancel the load.
- HOLD:
  - ack<=0.
  - If req[owner]==0 at an edge: early release.
  - Else if hold_cnt==0: normal release.
  - Else hold_cnt decrements.
  - Release: grant<=0, rr_ptr<=(owner==NUM_REQ-1)?0:owner+1, state<=IDLE.
- Latency (req sampled in IDLE at edge 0):
  - grant high after edge 1.
  - q updated and ack pulses after edge 2.
  - grant falls after edge 2+HOLD_CYCLES.
  - grant high time is HOLD_CYCLES+1 cycles without early release.
- Minimum spacing between grants is one IDLE cycle; a granted requester cannot win back-to-back while others request.
- clr:
  - At any edge, q<=0 and q_valid<=0.
  - Takes precedence over the LOAD write at the same edge; ack still pulses.
  - Does not affect the FSM, grant or rr_ptr.
- Req/wdata of non-owners are ignored outside IDLE.
- wdata[owner] is sampled only at the LOAD edge.
- grant and ack are never high for more than one requester.

Decomposition:
- Shared package dff_arb_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_LOAD=2'd1, ST_HOLD=2'd2;
  - default WIDTH/NUM_REQ constants.
- One combinational sub-module rr_pick (inputs req, rr_ptr; outputs winner index and found flag) implements the wrap-around search.

Test Plan:
1. Assert reset low during HOLD with q=4'h5 and grant=4'b0010 -> grant, ack, q and q_valid go to 0 immediately, before the next clk edge; FSM restarts in IDLE.
2. NUM_REQ=4, HOLD_CYCLES=2; req=4'b0100 with wdata[2]=4'hA, held -> grant=4'b0100 after edge 1; q=4'hA, q_valid=1 and ack=4'b0100 for one cycle after edge 2; grant=0 after edge 4; busy high across edges 1-4.
3. req=4'b1111 held continuously -> winners in order 0,1,2,3,0; one IDLE cycle between grants.
4. req[1] granted, req[1] dropped in the first HOLD cycle -> grant=0 at the next edge; rr_ptr=2; a pending req[3] is granted after the following edge.
5. clr=1 coincident with the LOAD edge for wdata=4'hF -> q=0, q_valid=0, ack still pulses; a later load without clr gives q=4'hF and q_valid=1.
6. HOLD_CYCLES=1, single req[0] -> grant high for exactly 2 cycles; ack pulse in the second.
